// File: rtl/apb_reg_arbiter_if.sv
// APB-style register bus shared between the arbiter (master) and the register slave.
// Widths follow the arbiter's ADDRW/DATAW.
interface apb_reg_arbiter_if #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32
);
  logic             sel;
  logic             enable;
  logic             write;
  logic [ADDRW-1:0] addr;
  logic [DATAW-1:0] wdata;
  logic [DATAW-1:0] rdata;

  modport master (output sel, enable, write, addr, wdata, input rdata);
  modport slave  (input sel, enable, write, addr, wdata, output rdata);
endinterface

// File: rtl/apb_reg_arbiter.sv
// Two-requester round-robin master for a single APB-style register slave.
// Illegal addresses complete locally with err and never reach the bus.
module apb_reg_arbiter #(
  parameter int ADDRW    = 32,
  parameter int DATAW    = 32,
  parameter int NUM_REGS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             we0,
  input  logic [ADDRW-1:0] addr0,
  input  logic [DATAW-1:0] wdata0,
  output logic             done0,
  output logic             err0,
  output logic [DATAW-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [ADDRW-1:0] addr1,
  input  logic [DATAW-1:0] wdata1,
  output logic             done1,
  output logic             err1,
  output logic [DATAW-1:0] rdata1,
  apb_reg_arbiter_if.master bus,
  output logic             busy,
  output logic             gnt_id
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [ADDRW-1:0] MAX_ADDR = ADDRW'(4 * (NUM_REGS - 1));

  function automatic logic addr_legal(input logic [ADDRW-1:0] a);
    return (a[1:0] == 2'b00) && (a <= MAX_ADDR);
  endfunction

  state_t           state_r, next_s;
  logic             grant_s, win_s, cur_gnt_s, legal_s;
  logic             win_we_s;
  logic [ADDRW-1:0] win_addr_s;
  logic [DATAW-1:0] win_wdata_s;

  logic             sel_r, enable_r, write_r, busy_r, gnt_id_r;
  logic [ADDRW-1:0] addr_r;
  logic [DATAW-1:0] wdata_r, rdata0_r, rdata1_r;
  logic             done0_r, done1_r, err0_r, err1_r;

  // Round-robin pick: on a tie the requester not granted last time wins.
  always_comb begin
    grant_s = 1'b0;
    win_s   = gnt_id_r;
    if (req0 && req1) begin
      grant_s = 1'b1;
      win_s   = ~gnt_id_r;
    end else if (req0) begin
      grant_s = 1'b1;
      win_s   = 1'b0;
    end else if (req1) begin
      grant_s = 1'b1;
      win_s   = 1'b1;
    end else begin
      grant_s = 1'b0;
      win_s   = gnt_id_r;
    end
  end

  assign win_we_s    = win_s ? we1 : we0;
  assign win_addr_s  = win_s ? addr1 : addr0;
  assign win_wdata_s = win_s ? wdata1 : wdata0;
  assign legal_s     = addr_legal(win_addr_s);
  assign cur_gnt_s   = (state_r == ST_IDLE) ? win_s : gnt_id_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; an illegal address skips straight to DONE.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          next_s = legal_s ? ST_SETUP : ST_DONE;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_SETUP:   next_s = ST_ACCESS;
      ST_ACCESS:  next_s = write_r ? ST_DONE : ST_CAPTURE;
      ST_CAPTURE: next_s = ST_DONE;
      ST_DONE:    next_s = ST_IDLE;
      default:    next_s = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_s so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r    <= 1'b0;
      enable_r <= 1'b0;
      write_r  <= 1'b0;
      addr_r   <= {ADDRW{1'b0}};
      wdata_r  <= {DATAW{1'b0}};
      busy_r   <= 1'b0;
      gnt_id_r <= 1'b1;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      err0_r   <= 1'b0;
      err1_r   <= 1'b0;
      rdata0_r <= {DATAW{1'b0}};
      rdata1_r <= {DATAW{1'b0}};
    end else begin
      sel_r    <= (next_s == ST_SETUP) || (next_s == ST_ACCESS);
      enable_r <= (next_s == ST_ACCESS);
      busy_r   <= (next_s != ST_IDLE);
      done0_r  <= (next_s == ST_DONE) && !cur_gnt_s;
      done1_r  <= (next_s == ST_DONE) && cur_gnt_s;
      // DONE is reached directly from IDLE only for a rejected address.
      err0_r   <= (next_s == ST_DONE) && !cur_gnt_s && (state_r == ST_IDLE);
      err1_r   <= (next_s == ST_DONE) && cur_gnt_s && (state_r == ST_IDLE);
      if ((state_r == ST_IDLE) && grant_s) begin
        gnt_id_r <= win_s;
        if (legal_s) begin
          write_r <= win_we_s;
          addr_r  <= win_addr_s;
          wdata_r <= win_wdata_s;
        end else if (win_s) begin
          rdata1_r <= {DATAW{1'b0}};
        end else begin
          rdata0_r <= {DATAW{1'b0}};
        end
      end else if (state_r == ST_CAPTURE) begin
        if (gnt_id_r) begin
          rdata1_r <= bus.rdata;
        end else begin
          rdata0_r <= bus.rdata;
        end
      end
    end
  end

  assign bus.sel    = sel_r;
  assign bus.enable = enable_r;
  assign bus.write  = write_r;
  assign bus.addr   = addr_r;
  assign bus.wdata  = wdata_r;
  assign busy       = busy_r;
  assign gnt_id     = gnt_id_r;
  assign done0      = done0_r;
  assign done1      = done1_r;
  assign err0       = err0_r;
  assign err1       = err1_r;
  assign rdata0     = rdata0_r;
  assign rdata1     = rdata1_r;

endmodule

// File: tb/tb_apb_reg_arbiter.sv
// Scoreboard bench for apb_reg_arbiter with a register-file slave that returns
// read data the cycle after ACCESS.
module tb_apb_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0, addr1 = 32'h0, wdata1 = 32'h0;
  logic        done0, err0, done1, err1, busy, gnt_id;
  logic [31:0] rdata0, rdata1;

  apb_reg_arbiter_if #(.ADDRW(32), .DATAW(32)) bus ();

  apb_reg_arbiter #(.ADDRW(32), .DATAW(32), .NUM_REGS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .err1(err1), .rdata1(rdata1),
    .bus(bus), .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  // Slave register file: registered read data, cleared by the shared reset.
  logic [31:0] mem [16];
  logic [31:0] srdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      srdata <= 32'h0;
    end else if (bus.sel && bus.enable) begin
      if (bus.write) mem[bus.addr[5:2]] <= bus.wdata;
      else srdata <= mem[bus.addr[5:2]];
    end
  end
  assign bus.rdata = srdata;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  typedef struct {
    bit          id;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Completion monitor: every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t it;
    if (rst_n && (done0 || done1)) begin
      check_eq("done_excl", {63'h0, done0 && done1}, 64'h0);
      if (sb.size() == 0) begin
        check_eq("unexp_done", 64'h1, 64'h0);
      end else begin
        it = sb.pop_front();
        check_eq("done_id", {63'h0, done1}, {63'h0, it.id});
        check_eq("done_err", {63'h0, done1 ? err1 : err0}, {63'h0, it.err});
        check_eq("done_cyc", 64'(cyc), 64'(it.cyc));
        if (it.chk_rd) check_eq("done_rdata", {32'h0, done1 ? rdata1 : rdata0}, {32'h0, it.rd});
      end
    end
  end

  task automatic set_req(input bit id, input bit v, input bit we, input logic [31:0] a,
                         input logic [31:0] wd);
    if (id) begin req1 = v; we1 = we; addr1 = a; wdata1 = wd; end
    else begin req0 = v; we0 = we; addr0 = a; wdata0 = wd; end
  endtask

  // One transfer from an IDLE negedge; returns at the following IDLE negedge.
  task automatic do_xfer(input bit id, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input bit exp_err, input bit chk_rd, input logic [31:0] exp_rd,
                         input int lat);
    exp_t it;
    it.id = id; it.err = exp_err; it.chk_rd = chk_rd; it.rd = exp_rd; it.cyc = cyc + lat;
    sb.push_back(it);
    set_req(id, 1'b1, we, a, wd);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check_eq("busy", {63'h0, busy}, 64'h1);
      if (k == 1) check_eq("gnt_id", {63'h0, gnt_id}, {63'h0, id});
      if (exp_err || k >= 3) begin
        check_eq("sel_idle", {62'h0, bus.sel, bus.enable}, 64'h0);
      end else begin
        check_eq("sel_en", {62'h0, bus.sel, bus.enable}, (k == 1) ? 64'h2 : 64'h3);
        check_eq("bus_addr_wr", {31'h0, bus.write, bus.addr}, {31'h0, we, a});
        if (we) check_eq("bus_wdata", {32'h0, bus.wdata}, {32'h0, wd});
      end
    end
    set_req(id, 1'b0, we, a, wd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t it;
    repeat (2) @(negedge clk);
    check_eq("rst_bus", {bus.sel, bus.enable, bus.write, bus.addr, bus.wdata[28:0]}, 64'h0);
    check_eq("rst_out", {done0, done1, err0, err1, busy, gnt_id}, 64'h1);
    check_eq("rst_rdata", {rdata0, rdata1}, 64'h0);
    rst_n = 1'b1;

    do_xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 3);
    do_xfer(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 4);
    do_xfer(1'b0, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    do_xfer(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 4);
    do_xfer(1'b0, 1'b0, 32'h28, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    do_xfer(1'b1, 1'b1, 32'h24, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0, 3);
    do_xfer(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D, 4);

    // req0 held across done0: a second write one IDLE cycle later, same bus timing.
    for (int i = 0; i < 2; i++) begin
      it.id = 1'b0; it.err = 1'b0; it.chk_rd = 1'b0; it.rd = 32'h0; it.cyc = cyc + 3 + 4 * i;
      sb.push_back(it);
    end
    set_req(1'b0, 1'b1, 1'b1, 32'h04, 32'h0404_0404);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1 || k == 5) check_eq("held_setup", {62'h0, bus.sel, bus.enable}, 64'h2);
      if (k == 2 || k == 6) check_eq("held_access", {62'h0, bus.sel, bus.enable}, 64'h3);
      if (k == 4) check_eq("held_idle", {63'h0, busy}, 64'h0);
    end
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Both requesting right after reset: grants alternate 0,1,0,1,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      it.id = i[0]; it.err = 1'b0; it.chk_rd = 1'b0; it.rd = 32'h0; it.cyc = cyc + 3 + 4 * i;
      sb.push_back(it);
    end
    set_req(1'b0, 1'b1, 1'b1, 32'h20, 32'h2020_2020);
    set_req(1'b1, 1'b1, 1'b1, 32'h24, 32'h2424_2424);
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (k == 2) check_eq("fair_first_addr", {32'h0, bus.addr}, 64'h20);
      if (k == 6) check_eq("fair_second_addr", {32'h0, bus.addr}, 64'h24);
      if (k == 19) set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    do_xfer(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h2020_2020, 4);
    do_xfer(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'h2424_2424, 4);

    // Reset during ACCESS of a write: outputs clear at once, no done pulse.
    set_req(1'b0, 1'b1, 1'b1, 32'h08, 32'h1234_5678);
    repeat (2) @(negedge clk);
    check_eq("pre_rst_access", {62'h0, bus.sel, bus.enable}, 64'h3);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_bus", {bus.sel, bus.enable, bus.write, bus.addr, bus.wdata[28:0]}, 64'h0);
    check_eq("mid_rst_out", {done0, done1, err0, err1, busy, gnt_id}, 64'h1);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("mid_rst_nodone", {62'h0, done0, done1}, 64'h0);
    rst_n = 1'b1;
    do_xfer(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b1, 32'h0, 4);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_reg_arbiter.md
Name: apb_reg_arbiter

Overview:
- Two-requester APB-style master that shares the register slave's single bus (addr/write/sel/enable/wdata/rdata) between a host port (req0) and a debug/test port (req1).
- Performs round-robin arbitration and runs the SETUP -> ACCESS bus sequence for the granted requester.
- Captures read data one cycle after ACCESS, which is when the slave returns it.
- Rejects illegal addresses locally, without driving a bus cycle.

Parameters:
- ADDRW, 32, address width (requester side and bus side)
- DATAW, 32, data width
- NUM_REGS, 10, number of 32-bit slave registers; legal addresses are 0x0 to 4*(NUM_REGS-1), word aligned

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 transfer request; held high until done0
- we0  in  1  requester 0 write (1) / read (0); stable while req0 high
- addr0  in  ADDRW  requester 0 address
- wdata0  in  DATAW  requester 0 write data
- done0  out  1  one-cycle completion pulse to requester 0
- err0  out  1  valid with done0; 1 = illegal address
- rdata0  out  DATAW  read data; valid with done0 and held until the next done0
- req1, we1, addr1, wdata1, done1, err1, rdata1  as above, for requester 1
- sel  out  1  bus select to slave
- enable  out  1  bus enable (ACCESS phase)
- write  out  1  bus direction
- addr  out  ADDRW  bus address
- wdata  out  DATAW  bus write data
- rdata  in  DATAW  slave read data
- busy  out  1  high in every state except IDLE
- gnt_id  out  1  index of the currently or last granted requester

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - sel, enable, write, addr, wdata = 0; done*, err*, rdata* = 0; busy = 0.
  - last_grant = 1, so requester 0 wins the first tie; gnt_id = 1.
  - A reset mid-transfer aborts the transfer with no done pulse; the slave is reset by the same rst_n.
- FSM states: IDLE, SETUP, ACCESS, CAPTURE, DONE.
- IDLE, arbitration:
  - Only req0 high -> grant 0. Only req1 high -> grant 1.
  - Both high -> grant the index != last_grant.
  - On grant: latch we/addr/wdata of the winner, update last_grant and gnt_id.
  - Legality check on the latched address: addr[1:0]==0 and addr <= 4*(NUM_REGS-1).
  - Legal -> SETUP. Illegal -> DONE with err set, rdata=0, no bus activity.
- SETUP (1 cycle): sel=1, enable=0; write/addr/wdata driven from latches -> ACCESS.
- ACCESS (1 cycle): sel=1, enable=1.
  - Write -> DONE.
  - Read -> CAPTURE.
- CAPTURE (1 cycle): sel=0, enable=0; rdata sampled at the end of this cycle into the granted rdataN -> DONE.
- DONE (1 cycle):
  - sel=0, enable=0.
  - doneN=1 and errN driven for the granted requester only; the other requester's done stays 0.
  - DONE -> IDLE unconditionally.
- Bus outputs:
  - addr/wdata/write hold their last values outside SETUP/ACCESS.
  - sel=0 and enable=0 in IDLE, CAPTURE and DONE.
- Latency, counting cycle 0 as the IDLE cycle in which req is sampled:
  - write: done in cycle 3
  - read: done in cycle 4
  - illegal address: done in cycle 1
- Minimum spacing between grants: one IDLE cycle after each DONE.
- Request rules:
  - reqN sampled only in IDLE.
  - Changes to a requester's inputs while it is granted are ignored; the latched values are used.
  - A requester must drop req in the cycle after done. If req is still high in IDLE, it is a new request.
- Fairness: with both requesters continuously requesting, grants strictly alternate (0,1,0,1,...).
- Write data is never modified; the slave owns field masking and read-only bits.

Test Plan:
- Reset, then req0 write addr=0x10 wdata=0xDEADBEEF -> sel=1/enable=0 in cycle 1, enable=1 in cycle 2 with write=1, addr=0x10; done0=1, err0=0 in cycle 3; done1 stays 0.
- After the write, req1 read addr=0x10 -> bus read in cycles 1-2; rdata1=0xDEADBEEF with done1 in cycle 4; gnt_id=1.
- req0 and req1 asserted in the same cycle right after reset (writes to 0x20 and 0x24) -> requester 0 served first, requester 1 next; grants alternate over 6 continuous requests (0,1,0,1,0,1).
- req0 read addr=0x13 (misaligned), then addr=0x28 with NUM_REGS=10 -> each gives done0=1, err0=1, rdata0=0 one cycle after the request; sel never asserted.
- rst_n pulsed low during ACCESS of a write -> all outputs 0 immediately and no done pulse; after reset release a new req1 is granted normally.
- req0 held high across done0 -> a second transfer is granted after one IDLE cycle with identical bus timing.
